gyro_sample_sequencer: RTL and testbench
========================================

# gyro_sample_sequencer

Controller that configures the three-axis SPI gyro at start-up and then schedules periodic burst reads of the X/Y/Z angular-rate registers. It drives a byte-level SPI master through a start/done handshake and owns the chip select. It assembles the six returned bytes into three signed 16-bit rates, which it presents with a one-cycle `sample_valid` strobe to the axes integrator. This sets the integrator's sample rate, so integrated angle is proportional to real time.

## Interface
- `SAMPLE_DIV`, 100000: clock cycles per sample tick (1 kHz at 100 MHz); must be ≥ 2.
- `CS_GAP`, 4: minimum cycles `spi_cs_n` stays high between transactions; must be ≥ 1.
- `CTRL1_VAL`, 8'h0F: value written to gyro register 0x20 (power on, all axes enabled).
- `CTRL4_VAL`, 8'h30: value written to gyro register 0x23 (full-scale select).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `spi_start` out 1: one-cycle pulse that launches one byte transfer.
- `spi_tx_byte` out 8: byte to shift out; valid in the `spi_start` cycle.
- `spi_done` in 1: one-cycle pulse from the byte master when the transfer has completed.
- `spi_rx_byte` in 8: received byte; valid in the `spi_done` cycle.
- `spi_cs_n` out 1: gyro chip select, active low.
- `angular_rate_x/y/z` out 16 each: latest rates, two's complement.
- `sample_valid` out 1: one-cycle pulse when the rate outputs update.
- `config_done` out 1: level signal, high once both configuration writes have completed.
- `overrun` out 1: sticky flag, set when a tick arrives while a read is still in progress.

## Operation
- States are RST_GAP, CFG1, GAP1, CFG4, IDLE, READ, PUBLISH, GAP.
- **Transaction framing** (same for every transaction):
  - `spi_cs_n` falls.
  - The first `spi_start` fires on the next cycle.
  - Each later `spi_start` fires on the cycle after the previous `spi_done`.
  - `spi_cs_n` rises on the cycle after the final `spi_done`.
- **RST_GAP:** after reset release, wait `CS_GAP` cycles, then go to CFG1.
- **CFG1:** send 8'h20, then `CTRL1_VAL`, then go to GAP1.
- **GAP1:** hold `CS_GAP` cycles, then go to CFG4.
- **CFG4:** send 8'h23, then `CTRL4_VAL`. `config_done` goes high in the cycle `spi_cs_n` rises. Then go to GAP, which returns to IDLE.
- **Tick counter:**
  - Free-running 0..`SAMPLE_DIV`-1 from reset release, wrapping to 0.
  - The tick is the cycle in which the count equals `SAMPLE_DIV`-1.
- **IDLE:** on a tick, go to READ.
- **READ:**
  - Send 8'hE8 (read, auto-increment, address 0x28), then six bytes of 8'h00.
  - Capture `spi_rx_byte` on the 2nd through 7th `spi_done` into b0..b5.
  - The response to the address byte is discarded.
- **PUBLISH** (single cycle, coincides with the `spi_cs_n` rise):
  - x = {b1,b0}, y = {b3,b2}, z = {b5,b4}.
  - All three outputs update together, with `sample_valid` high for exactly that cycle.
  - Then go to GAP (`CS_GAP` cycles) and return to IDLE.
- **Tick outside IDLE:**
  - Ticks outside IDLE are dropped, not queued.
  - If `config_done` is 1 and the state is not IDLE, set `overrun`. It is cleared only by `reset`.
  - Ticks before `config_done` never set `overrun`.
- A `spi_done` arriving while no transfer is outstanding is ignored.
- A `spi_start` is never issued while a transfer is outstanding.
- Rate outputs hold their value between PUBLISH cycles.

## Timing
- Reset values: `spi_cs_n`=1, `spi_start`=0, `spi_tx_byte`=0, rates=0, `sample_valid`=0, `config_done`=0, `overrun`=0, tick counter=0, state=RST_GAP.
- **Reset mid-transaction:** `spi_cs_n` goes to 1 asynchronously and all captured bytes are discarded. After release, the full configuration sequence reruns.
- **Read latency:** `spi_cs_n` falls the cycle after the tick. `sample_valid` fires the cycle after the 7th `spi_done`.
- **Chip-select low time:** with byte-master turnaround T cycles (`spi_start` to `spi_done`), `spi_cs_n` is low for 7(T+1)+1 cycles per read.
- **Tick/IDLE entry collision:** a tick in the same cycle the state enters IDLE from GAP is not taken and sets `overrun`.
- Outputs are all registered. No combinational path from `spi_done` or `spi_rx_byte` to any output.

## Test plan
- **Config sequence:** byte master model with T=16. After reset, check:
  - the bytes sent are 20,0F (cs high ≥4 cycles) then 23,30;
  - `config_done` rises with the second `spi_cs_n` rise;
  - no `sample_valid` occurs before it.
- **Single read:** `SAMPLE_DIV`=400. The model returns bytes XX,34,12,CD,AB,FF,7F.
  - Expect x=16'h1234, y=16'hABCD, z=16'h7FFF with one `sample_valid` pulse.
  - `sample_valid` is one cycle after the last `spi_done`.
- **Periodicity:** over 5 ticks, `sample_valid` pulses are exactly 400 cycles apart, the outputs hold between pulses, and `overrun` stays 0.
- **Overrun:** `SAMPLE_DIV`=100 with T=16, so a read takes longer than one period.
  - `overrun` sets on the first tick that lands mid-read and stays 1.
  - Reads still complete, one every other tick, with correct data.
- **Reset mid-read:** assert `reset` during the 4th byte.
  - `spi_cs_n` goes to 1 immediately, the outputs return to 0, and `config_done` returns to 0.
  - After release the config sequence repeats before the next read.
- **Spurious done:** a `spi_done` pulse while in IDLE causes no state change, no `spi_start`, and no output change.

Source files
------------

// File: rtl/gyro_sample_sequencer_if.sv
// Byte-level SPI master handshake plus gyro chip select.
//   master modport: the sequencer (drives start/tx_byte/cs_n, receives done/rx_byte)
//   slave modport : the byte master (receives start/tx_byte/cs_n, drives done/rx_byte)
// Signals:
//   spi_start   - one-cycle pulse launching one byte transfer
//   spi_tx_byte - byte to shift out, valid with spi_start
//   spi_done    - one-cycle pulse when the transfer has completed
//   spi_rx_byte - received byte, valid with spi_done
//   spi_cs_n    - gyro chip select, active low
interface gyro_sample_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_tx_byte;
  logic       spi_done;
  logic [7:0] spi_rx_byte;
  logic       spi_cs_n;

  modport master (
    output spi_start, spi_tx_byte, spi_cs_n,
    input  spi_done, spi_rx_byte
  );

  modport slave (
    input  spi_start, spi_tx_byte, spi_cs_n,
    output spi_done, spi_rx_byte
  );
endinterface

// File: rtl/gyro_sample_sequencer.sv
// Gyro start-up configuration and periodic X/Y/Z burst-read sequencer.
// Writes CTRL1 (0x20) and CTRL4 (0x23), then on every sample tick reads the
// six rate registers starting at 0x28 and publishes three signed 16-bit rates.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   spi               - byte master handshake and chip select (master modport)
//   angular_rate_x/y/z- latest rates, two's complement, held between updates
//   sample_valid      - one-cycle strobe when the rate outputs update
//   config_done       - high once both configuration writes have completed
//   overrun           - sticky, a tick arrived while a read was still running
module gyro_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned CS_GAP     = 4,
  parameter logic [7:0]  CTRL1_VAL  = 8'h0F,
  parameter logic [7:0]  CTRL4_VAL  = 8'h30
) (
  input  logic                           clk,
  input  logic                           reset,
  gyro_sample_sequencer_if.master        spi,
  output logic [15:0]                    angular_rate_x,
  output logic [15:0]                    angular_rate_y,
  output logic [15:0]                    angular_rate_z,
  output logic                           sample_valid,
  output logic                           config_done,
  output logic                           overrun
);

  localparam int unsigned TW = $clog2(SAMPLE_DIV);
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(CS_GAP - 1);

  localparam logic [2:0] ST_RST_GAP = 3'd0;
  localparam logic [2:0] ST_CFG1    = 3'd1;
  localparam logic [2:0] ST_GAP1    = 3'd2;
  localparam logic [2:0] ST_CFG4    = 3'd3;
  localparam logic [2:0] ST_IDLE    = 3'd4;
  localparam logic [2:0] ST_READ    = 3'd5;
  localparam logic [2:0] ST_PUBLISH = 3'd6;
  localparam logic [2:0] ST_GAP     = 3'd7;

  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    byte_idx;   // index of the byte currently in flight
  logic          busy;       // a transfer has been launched and not yet completed
  logic [7:0]    rx_buf [0:4];
  logic          tick;
  logic [2:0]    last_idx;

  assign tick     = (tick_cnt == TICK_LAST);
  assign last_idx = (state == ST_READ) ? 3'd6 : 3'd1;

  // Byte to send for a given transaction and position within it.
  function automatic logic [7:0] tx_for(input logic [2:0] st, input logic [2:0] idx);
    case (st)
      ST_CFG1: tx_for = (idx == 3'd0) ? 8'h20 : CTRL1_VAL;
      ST_CFG4: tx_for = (idx == 3'd0) ? 8'h23 : CTRL4_VAL;
      default: tx_for = (idx == 3'd0) ? 8'hE8 : 8'h00;
    endcase
  endfunction

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_RST_GAP;
      tick_cnt        <= '0;
      gap_cnt         <= GAP_LOAD;
      byte_idx        <= '0;
      busy            <= 1'b0;
      spi.spi_start   <= 1'b0;
      spi.spi_tx_byte <= 8'h00;
      spi.spi_cs_n    <= 1'b1;
      angular_rate_x  <= '0;
      angular_rate_y  <= '0;
      angular_rate_z  <= '0;
      sample_valid    <= 1'b0;
      config_done     <= 1'b0;
      overrun         <= 1'b0;
      // NOTE: the capture buffer is reset too, so a read cut short by reset
      // can never leak partial bytes into a later sample.
      for (int i = 0; i < 5; i++) rx_buf[i] <= 8'h00;
    end else begin
      spi.spi_start <= 1'b0;
      sample_valid  <= 1'b0;
      tick_cnt      <= tick ? '0 : tick_cnt + TW'(1);

      // Ticks outside IDLE are dropped; after configuration they flag overrun.
      if (tick && config_done && state != ST_IDLE) overrun <= 1'b1;

      case (state)
        ST_RST_GAP, ST_GAP1, ST_GAP: begin
          if (gap_cnt == '0) begin
            if (state == ST_GAP) begin
              state <= ST_IDLE;
            end else begin
              state        <= (state == ST_RST_GAP) ? ST_CFG1 : ST_CFG4;
              spi.spi_cs_n <= 1'b0;
              byte_idx     <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        ST_IDLE: begin
          if (tick) begin
            state        <= ST_READ;
            spi.spi_cs_n <= 1'b0;
            byte_idx     <= '0;
          end
        end

        ST_CFG1, ST_CFG4, ST_READ: begin
          if (!busy) begin
            // First byte goes out the cycle after chip select falls.
            spi.spi_start   <= 1'b1;
            spi.spi_tx_byte <= tx_for(state, 3'd0);
            busy            <= 1'b1;
          end else if (spi.spi_done) begin
            if (byte_idx == last_idx) begin
              busy         <= 1'b0;
              spi.spi_cs_n <= 1'b1;
              gap_cnt      <= GAP_LOAD;
              if (state == ST_CFG1) begin
                state <= ST_GAP1;
              end else if (state == ST_CFG4) begin
                state       <= ST_GAP;
                config_done <= 1'b1;
              end else begin
                // Last byte (b5) is taken straight from the bus so all three
                // rates update together in the chip-select rise cycle.
                state          <= ST_PUBLISH;
                angular_rate_x <= {rx_buf[1], rx_buf[0]};
                angular_rate_y <= {rx_buf[3], rx_buf[2]};
                angular_rate_z <= {spi.spi_rx_byte, rx_buf[4]};
                sample_valid   <= 1'b1;
              end
            end else begin
              // The reply to the address byte (index 0) is discarded.
              if (state == ST_READ && byte_idx != 3'd0)
                rx_buf[byte_idx - 3'd1] <= spi.spi_rx_byte;
              byte_idx        <= byte_idx + 3'd1;
              spi.spi_start   <= 1'b1;
              spi.spi_tx_byte <= tx_for(state, byte_idx + 3'd1);
            end
          end
        end

        ST_PUBLISH: state <= ST_GAP;

        default: state <= ST_RST_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_gyro_sample_sequencer.sv
// Self-checking bench for gyro_sample_sequencer: a byte-master model with a
// programmable turnaround, a scoreboard of expected transmitted bytes and
// expected rate samples, and a monitor that checks framing and timing.
module tb_gyro_sample_sequencer;
  localparam int DIV = 400;
  localparam int GAP = 4;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } rates_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rate_x, rate_y, rate_z;
  logic        sample_valid, config_done, overrun;

  gyro_sample_sequencer_if bus();

  gyro_sample_sequencer #(
    .SAMPLE_DIV(DIV),
    .CS_GAP    (GAP),
    .CTRL1_VAL (8'h0F),
    .CTRL4_VAL (8'h30)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spi           (bus.master),
    .angular_rate_x(rate_x),
    .angular_rate_y(rate_y),
    .angular_rate_z(rate_z),
    .sample_valid  (sample_valid),
    .config_done   (config_done),
    .overrun       (overrun)
  );

  initial forever #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_done_cyc = 0;
  longint last_sv_cyc = 0;
  longint rel_cyc = 0;
  int     done_total = 0;
  int     sample_cnt = 0;
  int     exp_period = 0;
  int     t_turn = 16;
  bit     inj_done = 1'b0;

  logic [7:0] exp_tx_q [$];
  logic [7:0] rx_q [$];
  rates_t     exp_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_cfg();
    exp_tx_q.push_back(8'h20); exp_tx_q.push_back(8'h0F);
    exp_tx_q.push_back(8'h23); exp_tx_q.push_back(8'h30);
    repeat (4) rx_q.push_back(8'hFF);
  endtask

  // bytes: the seven bytes returned by the gyro, first byte in [55:48].
  task automatic push_read(input logic [55:0] bytes, input rates_t e);
    exp_tx_q.push_back(8'hE8);
    repeat (6) exp_tx_q.push_back(8'h00);
    for (int i = 0; i < 7; i++) rx_q.push_back(bytes[55 - 8*i -: 8]);
    exp_q.push_back(e);
  endtask

  task automatic wait_samples(input int n, input int budget);
    int target;
    int k;
    target = sample_cnt + n;
    k = 0;
    while (sample_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(sample_cnt >= target, "sample_timeout", sample_cnt, target);
  endtask

  // Byte-master model: done follows start by t_turn cycles.
  initial begin : byte_master
    int         pend;
    logic [7:0] rx_next;
    logic [7:0] e;
    pend = 0;
    rx_next = 8'h00;
    bus.spi_done = 1'b0;
    bus.spi_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (inj_done) begin
          bus.spi_done = 1'b1;
          bus.spi_rx_byte = 8'h5A;
          inj_done = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.spi_done = 1'b1;
            bus.spi_rx_byte = rx_next;
            done_total++;
            last_done_cyc = cyc;
          end
        end
        if (bus.spi_start) begin
          check(pend == 0, "start_while_busy", pend, 0);
          check(!bus.spi_cs_n, "start_cs_low", bus.spi_cs_n, 0);
          if (exp_tx_q.size() == 0) begin
            check(1'b0, "unexpected_start", bus.spi_tx_byte, 0);
          end else begin
            e = exp_tx_q.pop_front();
            check(bus.spi_tx_byte == e, "tx_byte", bus.spi_tx_byte, e);
          end
          rx_next = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
          pend = t_turn;
        end
      end
    end
  end

  // Monitor: chip-select framing, config_done timing, sample scoreboard.
  initial begin : monitor
    logic   prev_cs, prev_sv;
    int     cs_high_run, cs_rises;
    bit     hold_bad;
    rates_t held, got, e;
    prev_cs = 1'b1; prev_sv = 1'b0; cs_high_run = 0; cs_rises = 0;
    hold_bad = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      got = {rate_x, rate_y, rate_z};
      if (reset) begin
        prev_cs = 1'b1; prev_sv = 1'b0; cs_high_run = 0; cs_rises = 0;
        hold_bad = 1'b0; held = '0;
      end else begin
        if (!bus.spi_cs_n && prev_cs)
          check(cs_high_run >= GAP, "cs_gap", cs_high_run, GAP);
        cs_high_run = bus.spi_cs_n ? cs_high_run + 1 : 0;
        if (bus.spi_cs_n && !prev_cs) begin
          cs_rises++;
          if (cs_rises == 1)
            check(config_done == 1'b0, "cfg_done_early", config_done, 0);
          else if (cs_rises == 2)
            check(config_done == 1'b1, "cfg_done_rise", config_done, 1);
        end
        if (sample_valid) begin
          sample_cnt++;
          check(!prev_sv, "sv_one_cycle", prev_sv, 0);
          check(config_done, "sv_before_cfg", config_done, 1);
          check(bus.spi_cs_n && !prev_cs, "sv_cs_rise", bus.spi_cs_n, 1);
          check(cyc - last_done_cyc == 1, "sv_latency", cyc - last_done_cyc, 1);
          check(!hold_bad, "rate_hold", hold_bad, 0);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_sample", got, 0);
          end else begin
            e = exp_q.pop_front();
            check(got.x == e.x, "rate_x", got.x, e.x);
            check(got.y == e.y, "rate_y", got.y, e.y);
            check(got.z == e.z, "rate_z", got.z, e.z);
          end
          if (exp_period != 0)
            check(cyc - last_sv_cyc == exp_period, "period", cyc - last_sv_cyc, exp_period);
          last_sv_cyc = cyc;
          held = got;
          hold_bad = 1'b0;
        end else if (got != held) begin
          hold_bad = 1'b1;
        end
        prev_cs = bus.spi_cs_n;
        prev_sv = sample_valid;
      end
    end
  end

  initial begin : stimulus
    int k;
    int d0;
    bit start_seen;
    reset = 1'b1;
    push_cfg();
    push_read(56'hA5_34_12_CD_AB_FF_7F, {16'h1234, 16'hABCD, 16'h7FFF});
    repeat (3) @(posedge clk);
    #1;
    check(bus.spi_cs_n == 1'b1, "rst_cs_n", bus.spi_cs_n, 1);
    check(bus.spi_start == 1'b0, "rst_start", bus.spi_start, 0);
    check(bus.spi_tx_byte == 8'h00, "rst_tx_byte", bus.spi_tx_byte, 0);
    check({rate_x, rate_y, rate_z} == '0, "rst_rates", {rate_x, rate_y, rate_z}, 0);
    check(sample_valid == 1'b0, "rst_sample_valid", sample_valid, 0);
    check(config_done == 1'b0, "rst_config_done", config_done, 0);
    check(overrun == 1'b0, "rst_overrun", overrun, 0);

    // Config then first read: tick at cycle 399, cs low 400..519, sample at 520.
    @(posedge clk); #1;
    reset = 1'b0;
    rel_cyc = cyc;
    wait_samples(1, 1200);
    check(last_sv_cyc - rel_cyc == 520, "first_read_latency", last_sv_cyc - rel_cyc, 520);

    // Periodicity.
    exp_period = DIV;
    push_read(56'h00_00_80_01_00_FF_FF, {16'h8000, 16'h0001, 16'hFFFF});
    push_read(56'h11_EF_BE_AD_DE_00_00, {16'hBEEF, 16'hDEAD, 16'h0000});
    push_read(56'h22_78_56_34_12_CD_AB, {16'h5678, 16'h1234, 16'hABCD});
    push_read(56'h33_FF_7F_00_80_02_00, {16'h7FFF, 16'h8000, 16'h0002});
    push_read(56'h44_01_00_FE_FF_10_20, {16'h0001, 16'hFFFE, 16'h2010});
    wait_samples(5, 5 * DIV + 200);
    check(overrun == 1'b0, "no_overrun_periodic", overrun, 0);

    // Spurious done while idle.
    push_read(56'h55_AA_55_55_AA_0F_F0, {16'h55AA, 16'hAA55, 16'hF00F});
    repeat (10) @(posedge clk);
    #1;
    inj_done = 1'b1;
    start_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.spi_start || !bus.spi_cs_n) start_seen = 1'b1;
    end
    check(!start_seen, "spurious_done_activity", start_seen, 0);
    wait_samples(1, DIV + 200);
    check(overrun == 1'b0, "no_overrun_after_spurious", overrun, 0);

    // Overrun: a read now outlasts one sample period.
    t_turn = 60;
    exp_period = 0;
    push_read(56'h66_21_43_65_87_A9_CB, {16'h4321, 16'h8765, 16'hCBA9});
    wait_samples(1, 2 * DIV + 200);
    check(overrun == 1'b1, "overrun_set", overrun, 1);
    exp_period = 2 * DIV;
    push_read(56'h77_0D_F0_AD_0B_EF_BE, {16'hF00D, 16'h0BAD, 16'hBEEF});
    push_read(56'h88_FE_CA_BE_BA_00_01, {16'hCAFE, 16'hBABE, 16'h0100});
    wait_samples(2, 4 * DIV + 200);
    check(overrun == 1'b1, "overrun_sticky", overrun, 1);

    // Reset during the 4th byte of a read.
    exp_period = 0;
    push_read(56'h99_11_22_33_44_55_66, {16'h2211, 16'h4433, 16'h6655});
    k = 0;
    while (bus.spi_cs_n && k < 2 * DIV) begin
      @(negedge clk);
      k++;
    end
    check(!bus.spi_cs_n, "read_start_timeout", bus.spi_cs_n, 0);
    d0 = done_total;
    k = 0;
    while (done_total < d0 + 3 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(done_total >= d0 + 3, "third_done_timeout", done_total - d0, 3);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check(bus.spi_cs_n == 1'b1, "midread_rst_cs_n", bus.spi_cs_n, 1);
    check({rate_x, rate_y, rate_z} == '0, "midread_rst_rates", {rate_x, rate_y, rate_z}, 0);
    check(config_done == 1'b0, "midread_rst_config_done", config_done, 0);
    check(overrun == 1'b0, "midread_rst_overrun", overrun, 0);
    exp_tx_q.delete();
    rx_q.delete();
    exp_q.delete();
    t_turn = 16;
    push_cfg();
    push_read(56'hAB_0C_0B_0E_0D_0F_0E, {16'h0B0C, 16'h0D0E, 16'h0E0F});
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rel_cyc = cyc;
    wait_samples(1, 1200);
    check(last_sv_cyc - rel_cyc == 520, "post_reset_read_latency", last_sv_cyc - rel_cyc, 520);
    check(overrun == 1'b0, "post_reset_overrun", overrun, 0);
    check(exp_tx_q.size() == 0, "tx_bytes_left", exp_tx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
